// File: rtl/lsu_mem_stage_if.sv
// ---------------------------------------------------------------------------
// lsu_mem_stage_if
// Word-wide req/ack data bus between the load/store unit and memory.
//   bus_req   : request, held by the master until bus_ack
//   bus_we    : 1 = write, 0 = read
//   bus_addr  : word-aligned address
//   bus_be    : byte-lane enables
//   bus_wdata : lane-replicated store data
//   bus_ack   : one-cycle completion from memory
//   bus_rdata : read word, valid with bus_ack
// ---------------------------------------------------------------------------
interface lsu_mem_stage_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/lsu_mem_stage.sv
// ---------------------------------------------------------------------------
// lsu_mem_stage
// Multi-cycle load/store unit sitting after the ALU. The ALU result is the
// effective address, rs2 is the store data. One access at a time is issued
// on a req/ack bus; loads return lane-selected, sign/zero-extended data.
// The core is stalled while an instruction is in flight.
//
// Ports:
//   clk, rst_n          : clock (rising edge), async active-low reset
//   start               : current instruction is a memory op, held until done
//   mem_read, mem_write : load / store select
//   funct3              : 000 B, 001 H, 010 W, 100 BU, 101 HU
//   addr, wdata         : effective address, store data
//   stall               : start & ~done (combinational)
//   done                : one-cycle registered completion pulse
//   rdata               : extended load data, updated on successful load only
//   misaligned, err     : status, valid with done
//   bus                 : master side of lsu_mem_stage_if
// ---------------------------------------------------------------------------
module lsu_mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   mem_read,
  input  logic                   mem_write,
  input  logic [2:0]             funct3,
  input  logic [31:0]            addr,
  input  logic [31:0]            wdata,
  output logic                   stall,
  output logic                   done,
  output logic [31:0]            rdata,
  output logic                   misaligned,
  output logic                   err,
  lsu_mem_stage_if.master        bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Last counter value at which a missing ack is declared a timeout.
  localparam int unsigned        TO_M1   = (TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0;
  localparam logic [CNT_W-1:0]   TO_LAST = CNT_W'(TO_M1);
  localparam bit                 TO_EN   = (TIMEOUT_CYCLES > 0);

  // Byte-lane enables from access size and address offset.
  function automatic logic [3:0] calc_be(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << {off[1], 1'b0};
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Store data replicated across all lanes so the byte enables pick the target.
  function automatic logic [31:0] calc_wdata(input logic [1:0] size, input logic [31:0] d);
    logic [31:0] w;
    case (size)
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  // Shift the addressed lane down to bit 0 and extend it to 32 bits.
  function automatic logic [31:0] extend_load(input logic [31:0] word,
                                              input logic [1:0]  off,
                                              input logic [2:0]  f3);
    logic [31:0] sh;
    logic [31:0] r;
    sh = word >> {off, 3'b000};
    case (f3)
      3'b000:  r = {{24{sh[7]}}, sh[7:0]};
      3'b001:  r = {{16{sh[15]}}, sh[15:0]};
      3'b100:  r = {24'h000000, sh[7:0]};
      3'b101:  r = {16'h0000, sh[15:0]};
      default: r = sh;
    endcase
    return r;
  endfunction

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [2:0]        f3_r, f3_s;
  logic [1:0]        off_r, off_s;
  logic              done_r, done_s;
  logic              mis_r, mis_s;
  logic              err_r, err_s;
  logic [31:0]       rdata_r, rdata_s;
  logic              req_r, req_s;
  logic              we_r, we_s;
  logic [31:0]       baddr_r, baddr_s;
  logic [3:0]        be_r, be_s;
  logic [31:0]       bwdata_r, bwdata_s;

  logic              illegal_s;
  logic              misal_s;
  logic              timeout_s;

  // Decode of the op presented in IDLE: illegal combinations and misalignment.
  always_comb begin
    illegal_s = 1'b0;
    misal_s   = 1'b0;
    if (mem_read == mem_write) begin
      illegal_s = 1'b1;
    end else if (mem_read) begin
      illegal_s = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    end else begin
      illegal_s = (funct3 != 3'b000) && (funct3 != 3'b001) && (funct3 != 3'b010);
    end
    if (funct3[1:0] == 2'b01) begin
      misal_s = addr[0];
    end else if (funct3[1:0] == 2'b10) begin
      misal_s = (addr[1:0] != 2'b00);
    end else begin
      misal_s = 1'b0;
    end
  end

  assign timeout_s = TO_EN && (cnt_r == TO_LAST);

  // Next-state and next-register logic for the IDLE/ACCESS/DONE sequencer.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    f3_s     = f3_r;
    off_s    = off_r;
    done_s   = 1'b0;
    mis_s    = 1'b0;
    err_s    = 1'b0;
    rdata_s  = rdata_r;
    req_s    = req_r;
    we_s     = we_r;
    baddr_s  = baddr_r;
    be_s     = be_r;
    bwdata_s = bwdata_r;
    case (state_r)
      IDLE: begin
        if (!start) begin
          state_s = IDLE;
        end else if (illegal_s) begin
          err_s   = 1'b1;
          done_s  = 1'b1;
          state_s = DONE;
        end else if (misal_s) begin
          mis_s   = 1'b1;
          done_s  = 1'b1;
          state_s = DONE;
        end else begin
          baddr_s  = {addr[31:2], 2'b00};
          be_s     = calc_be(funct3[1:0], addr[1:0]);
          bwdata_s = calc_wdata(funct3[1:0], wdata);
          we_s     = mem_write;
          f3_s     = funct3;
          off_s    = addr[1:0];
          cnt_s    = '0;
          req_s    = 1'b1;
          state_s  = ACCESS;
        end
      end
      ACCESS: begin
        cnt_s = cnt_r + CNT_W'(1);
        // Ack has priority over a timeout landing in the same cycle.
        if (bus.bus_ack) begin
          req_s = 1'b0;
          if (!we_r) begin
            rdata_s = extend_load(bus.bus_rdata, off_r, f3_r);
          end else begin
            rdata_s = rdata_r;
          end
          done_s  = 1'b1;
          state_s = DONE;
        end else if (timeout_s) begin
          req_s   = 1'b0;
          err_s   = 1'b1;
          done_s  = 1'b1;
          state_s = DONE;
        end else begin
          state_s = ACCESS;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        req_s   = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers; reset clears the bus request immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      f3_r     <= 3'b000;
      off_r    <= 2'b00;
      done_r   <= 1'b0;
      mis_r    <= 1'b0;
      err_r    <= 1'b0;
      rdata_r  <= 32'h0000_0000;
      req_r    <= 1'b0;
      we_r     <= 1'b0;
      baddr_r  <= 32'h0000_0000;
      be_r     <= 4'b0000;
      bwdata_r <= 32'h0000_0000;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      f3_r     <= f3_s;
      off_r    <= off_s;
      done_r   <= done_s;
      mis_r    <= mis_s;
      err_r    <= err_s;
      rdata_r  <= rdata_s;
      req_r    <= req_s;
      we_r     <= we_s;
      baddr_r  <= baddr_s;
      be_r     <= be_s;
      bwdata_r <= bwdata_s;
    end
  end

  assign stall         = start & ~done_r;
  assign done          = done_r;
  assign misaligned    = mis_r;
  assign err           = err_r;
  assign rdata         = rdata_r;
  assign bus.bus_req   = req_r;
  assign bus.bus_we    = we_r;
  assign bus.bus_addr  = baddr_r;
  assign bus.bus_be    = be_r;
  assign bus.bus_wdata = bwdata_r;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_lsu_mem_stage
// Directed bench for lsu_mem_stage: loads/stores of each size, misaligned and
// illegal ops, bus timeout, late ack, stray ack and reset during an access.
// ---------------------------------------------------------------------------
module tb_lsu_mem_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        stall;
  logic        done;
  logic [31:0] rdata;
  logic        misaligned;
  logic        err;

  int vectors = 0;
  int miscompares = 0;

  // Values captured by run_op
  int          lat;
  int          reqs;
  logic        stall_ok;
  logic        o_we;
  logic [3:0]  o_be;
  logic [31:0] o_addr;
  logic [31:0] o_wdata;
  logic [31:0] o_rdata;
  logic        o_err;
  logic        o_mis;

  lsu_mem_stage_if bus_if();

  lsu_mem_stage #(.TIMEOUT_CYCLES(16), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .stall      (stall),
    .done       (done),
    .rdata      (rdata),
    .misaligned (misaligned),
    .err        (err),
    .bus        (bus_if)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one op (cycle 0 = now), act as memory acking after 'waits'
  // request cycles, and return once done has been seen and retired.
  task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int waits, input logic [31:0] rdat);
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
    start = 1'b1;
    #1;
    lat = -1; reqs = 0; stall_ok = 1'b1;
    o_we = 1'b0; o_be = 4'h0; o_addr = 32'h0; o_wdata = 32'h0;
    o_rdata = 32'h0; o_err = 1'b0; o_mis = 1'b0;
    for (int c = 0; c < 64; c++) begin
      if (done === 1'b1) begin
        lat = c; o_rdata = rdata; o_err = err; o_mis = misaligned;
        break;
      end
      if (stall !== 1'b1) stall_ok = 1'b0;
      if (bus_if.bus_req === 1'b1) begin
        reqs++;
        if (reqs == 1) begin
          o_we = bus_if.bus_we; o_be = bus_if.bus_be;
          o_addr = bus_if.bus_addr; o_wdata = bus_if.bus_wdata;
        end
        if (reqs > waits) begin
          bus_if.bus_ack = 1'b1; bus_if.bus_rdata = rdat;
        end
      end
      tick;
      bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'h0;
    end
    start = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    if (lat >= 0) tick;
  endtask

  initial begin
    bus_if.bus_ack = 1'b0;
    bus_if.bus_rdata = 32'h0;

    // Reset state
    tick;
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_req", {31'h0, bus_if.bus_req}, 32'h0);
    chk("rst_be", {28'h0, bus_if.bus_be}, 32'h0);
    chk("rst_addr", bus_if.bus_addr, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    tick;

    // LW with two wait cycles
    run_op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 2, 32'hDEADBEEF);
    chk("lw_lat", 32'(lat), 32'd4);
    chk("lw_be", {28'h0, o_be}, 32'hF);
    chk("lw_addr", o_addr, 32'h100);
    chk("lw_we", {31'h0, o_we}, 32'h0);
    chk("lw_rdata", o_rdata, 32'hDEADBEEF);
    chk("lw_stall", {31'h0, stall_ok}, 32'h1);
    chk("lw_err", {31'h0, o_err}, 32'h0);

    // Byte / halfword loads
    run_op(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 0, 32'h80123456);
    chk("lb_lat", 32'(lat), 32'd2);
    chk("lb_be", {28'h0, o_be}, 32'h8);
    chk("lb_addr", o_addr, 32'h100);
    chk("lb_rdata", o_rdata, 32'hFFFFFF80);
    run_op(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 0, 32'h80123456);
    chk("lbu_rdata", o_rdata, 32'h00000080);
    run_op(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 0, 32'h80123456);
    chk("lhu_be", {28'h0, o_be}, 32'hC);
    chk("lhu_rdata", o_rdata, 32'h00008012);
    run_op(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 0, 32'h80123456);
    chk("lh_rdata", o_rdata, 32'hFFFF8012);
    run_op(1'b1, 1'b0, 3'b000, 32'h101, 32'h0, 1, 32'h80123456);
    chk("lb1_be", {28'h0, o_be}, 32'h2);
    chk("lb1_lat", 32'(lat), 32'd3);
    chk("lb1_rdata", o_rdata, 32'h00000034);

    // Stores leave rdata alone
    run_op(1'b0, 1'b1, 3'b001, 32'h206, 32'h0000ABCD, 0, 32'hFFFFFFFF);
    chk("sh_we", {31'h0, o_we}, 32'h1);
    chk("sh_be", {28'h0, o_be}, 32'hC);
    chk("sh_wdata", o_wdata, 32'hABCDABCD);
    chk("sh_addr", o_addr, 32'h204);
    chk("sh_rdata", o_rdata, 32'h00000034);
    run_op(1'b0, 1'b1, 3'b000, 32'h201, 32'h12345677, 0, 32'h0);
    chk("sb_be", {28'h0, o_be}, 32'h2);
    chk("sb_wdata", o_wdata, 32'h77777777);

    // Misaligned and illegal ops: done in cycle 1, no bus request
    run_op(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 0, 32'h0);
    chk("lw_mis_lat", 32'(lat), 32'd1);
    chk("lw_mis", {31'h0, o_mis}, 32'h1);
    chk("lw_mis_err", {31'h0, o_err}, 32'h0);
    chk("lw_mis_req", 32'(reqs), 32'd0);
    run_op(1'b0, 1'b1, 3'b001, 32'h101, 32'h0, 0, 32'h0);
    chk("sh_mis", {31'h0, o_mis}, 32'h1);
    chk("sh_mis_req", 32'(reqs), 32'd0);
    run_op(1'b1, 1'b1, 3'b010, 32'h100, 32'h0, 0, 32'h0);
    chk("rw_lat", 32'(lat), 32'd1);
    chk("rw_err", {31'h0, o_err}, 32'h1);
    chk("rw_mis", {31'h0, o_mis}, 32'h0);
    chk("rw_req", 32'(reqs), 32'd0);
    run_op(1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 0, 32'h0);
    chk("ld011_err", {31'h0, o_err}, 32'h1);
    run_op(1'b0, 1'b1, 3'b100, 32'h100, 32'h0, 0, 32'h0);
    chk("sbu_err", {31'h0, o_err}, 32'h1);
    chk("err_rdata", o_rdata, 32'h00000034);

    // Timeout after 16 request cycles
    run_op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 1000, 32'h0);
    chk("to_reqs", 32'(reqs), 32'd16);
    chk("to_lat", 32'(lat), 32'd17);
    chk("to_err", {31'h0, o_err}, 32'h1);
    chk("to_rdata", o_rdata, 32'h00000034);
    // Ack on the 16th cycle wins
    run_op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 15, 32'h13579BDF);
    chk("late_reqs", 32'(reqs), 32'd16);
    chk("late_err", {31'h0, o_err}, 32'h0);
    chk("late_rdata", o_rdata, 32'h13579BDF);

    // Stray ack in IDLE is ignored
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'hFFFFFFFF;
    tick;
    bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'h0;
    chk("stray_done", {31'h0, done}, 32'h0);
    tick;
    chk("stray_done2", {31'h0, done}, 32'h0);
    chk("stray_rdata", rdata, 32'h13579BDF);

    // Reset in the middle of an access
    mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h100;
    start = 1'b1;
    tick; tick;
    chk("mid_req", {31'h0, bus_if.bus_req}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", {31'h0, bus_if.bus_req}, 32'h0);
    chk("arst_done", {31'h0, done}, 32'h0);
    chk("arst_rdata", rdata, 32'h0);
    start = 1'b0; mem_read = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    tick;
    run_op(1'b0, 1'b1, 3'b010, 32'h300, 32'hCAFEF00D, 0, 32'h0);
    chk("sw_lat", 32'(lat), 32'd2);
    chk("sw_we", {31'h0, o_we}, 32'h1);
    chk("sw_be", {28'h0, o_be}, 32'hF);
    chk("sw_wdata", o_wdata, 32'hCAFEF00D);
    chk("sw_addr", o_addr, 32'h300);
    chk("sw_err", {31'h0, o_err}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Multi-cycle load/store unit directly downstream of the ALU.
- Takes the ALU result as the effective address and rs2 as store data.
- Drives a req/ack data bus and returns aligned, sign- or zero-extended load data to write-back.
- Stalls the single-cycle core while an access is in flight.

Parameters:
TIMEOUT_CYCLES, 16, max ACCESS cycles waiting for bus_ack before error; 0 disables timeout
CNT_W, 8, width of timeout counter; must hold TIMEOUT_CYCLES

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  current instruction is a memory op; held by core until done
mem_read  in  1  load
mem_write  in  1  store
funct3  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
addr  in  32  effective address (ALU result)
wdata  in  32  store data (rs2)
stall  out  1  combinational: start & ~done
done  out  1  one-cycle completion pulse (registered)
rdata  out  32  extended load data, valid when done on successful load
misaligned  out  1  valid with done; access not issued
err  out  1  valid with done; illegal op or bus timeout
bus_req  out  1  bus request, held until bus_ack
bus_we  out  1  1 = write
bus_addr  out  32  {addr[31:2],2'b00}
bus_be  out  4  byte lanes
bus_wdata  out  32  lane-replicated store data
bus_ack  in  1  one-cycle completion from memory
bus_rdata  in  32  read word, valid with bus_ack

Behaviour:
- Reset (async, immediate): state IDLE; done, misaligned, err, bus_req, bus_we = 0; bus_addr, bus_be, bus_wdata, rdata, counter = 0. Reset during ACCESS drops bus_req at once.
- FSM states: IDLE, ACCESS, DONE.
- IDLE, start=0: stay IDLE.
- IDLE, start=1, illegal op: go DONE with err=1. Illegal = mem_read==mem_write; load funct3 in {011,110,111}; store funct3 not in {000,001,010}.
- IDLE, start=1, misaligned: go DONE with misaligned=1. Misaligned = H/HU with addr[0]=1, or W with addr[1:0]!=0.
- IDLE, start=1, otherwise: latch bus_addr, bus_be, bus_wdata, bus_we=mem_write, funct3, addr[1:0]; assert bus_req; go ACCESS.
- Byte enables: B/BU 0001<<addr[1:0]; H/HU 0011<<{addr[1],1'b0}; W 1111. Same for loads and stores.
- Store data: SB {4{wdata[7:0]}}; SH {2{wdata[15:0]}}; SW wdata.
- ACCESS: bus outputs stable until ack; counter increments each cycle.
- On bus_ack: drop bus_req; for loads, select lane by latched offset, extend (B/H sign, BU/HU zero), write rdata; go DONE.
- Timeout: no ack while counter==TIMEOUT_CYCLES-1 (TIMEOUT_CYCLES>0) -> drop bus_req, err=1, go DONE.
- bus_ack and timeout in the same cycle: ack wins, no err.
- DONE: done=1 for exactly one cycle; start ignored (core advances on this edge); next state IDLE; done/misaligned/err clear.
- rdata updates only on successful load; holds across stores and errors.
- bus_ack outside ACCESS is ignored.
- Latency, aligned access with ack on first ACCESS cycle: start sampled cycle 0, bus_req cycle 1, done cycle 2. Each extra wait cycle adds one.
- Latency, misaligned/illegal: done in cycle 1, bus_req never asserted.
- Back-to-back ops: min 3 cycles each (IDLE, ACCESS, DONE).

Test Plan:
- LW addr=0x100, bus_rdata=0xDEADBEEF, ack after 2 wait cycles -> bus_be=1111, bus_addr=0x100, done 4 cycles after start, rdata=0xDEADBEEF, stall high until done.
- LB addr=0x103, bus_rdata=0x80123456 -> bus_be=1000, rdata=0xFFFFFF80; repeat as LBU -> rdata=0x00000080; LHU addr=0x102 -> rdata=0x00008012.
- SH addr=0x206, wdata=0x0000ABCD -> bus_we=1, bus_be=1100, bus_wdata=0xABCDABCD, bus_addr=0x204, rdata unchanged.
- LW addr=0x102; SH addr=0x101; mem_read=mem_write=1 -> done in cycle 1 with misaligned=1, misaligned=1, err=1 respectively; bus_req never high.
- TIMEOUT_CYCLES=16, bus_ack never asserted -> bus_req high exactly 16 cycles, then done=1, err=1; ack arriving on 16th cycle -> no err.
- rst_n low mid-ACCESS -> bus_req and stall-driving state clear immediately; after release, new SW completes normally with done 2 cycles after start.
